// File: rtl/wall_flag_if.sv
// Handshake bundle between a tile pixel source, the wall-flag decoder and the wall-flag consumer.
// walls bit order is {left, top, right, bottom}.
interface wall_flag_if;
  logic       pix_valid;
  logic       pix_ready;
  logic       pix_data;
  logic       pix_sof;
  logic       walls_valid;
  logic       walls_ready;
  logic [3:0] walls;
  logic       err;

  modport master (
    output pix_valid, pix_data, pix_sof, walls_ready,
    input  pix_ready, walls_valid, walls, err
  );

  modport slave (
    input  pix_valid, pix_data, pix_sof, walls_ready,
    output pix_ready, walls_valid, walls, err
  );
endinterface

// File: rtl/wall_flag_decoder.sv
// Recovers {left, top, right, bottom} wall flags from a raster-ordered 1-bit tile stream,
// flagging partially drawn edges and mid-tile resyncs as errors.
module wall_flag_decoder #(
  parameter int unsigned TILE_BITS   = 4,
  parameter int unsigned EDGE_MARGIN = 2
) (
  input  logic        clk,
  input  logic        rst,
  wall_flag_if.slave  bus
);

  localparam int unsigned N = 1 << TILE_BITS;
  localparam logic [TILE_BITS-1:0] LO  = TILE_BITS'(EDGE_MARGIN);
  localparam logic [TILE_BITS-1:0] HI  = TILE_BITS'(N - 1 - EDGE_MARGIN);
  localparam logic [TILE_BITS-1:0] MAX = TILE_BITS'(N - 1);

  typedef enum logic {COLLECT, DONE} state_t;

  state_t               state_q, state_d;
  logic [TILE_BITS-1:0] x_q, x_d, y_q, y_d;
  logic [3:0]           all1_q, all1_d, any1_q, any1_d;
  logic                 resync_q, resync_d;
  logic [3:0]           walls_q, walls_d;
  logic                 err_q, err_d;
  logic                 walls_valid_q, walls_valid_d;
  logic                 pix_ready_q, pix_ready_d;

  logic [TILE_BITS-1:0] cx, cy;
  logic [3:0]           acc_all, acc_any, hit;
  logic                 rs;

  function automatic logic in_rng(input logic [TILE_BITS-1:0] v);
    return (v >= LO) && (v <= HI);
  endfunction

  // Next-state: a sof beat restarts position and accumulators from (0,0).
  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    all1_d        = all1_q;
    any1_d        = any1_q;
    resync_d      = resync_q;
    walls_d       = walls_q;
    err_d         = err_q;
    walls_valid_d = walls_valid_q;
    pix_ready_d   = pix_ready_q;
    cx            = '0;
    cy            = '0;
    acc_all       = '1;
    acc_any       = '0;
    hit           = '0;
    rs            = 1'b0;

    case (state_q)
      COLLECT: begin
        pix_ready_d   = 1'b1;
        walls_valid_d = 1'b0;
        if (bus.pix_valid && pix_ready_q) begin
          cx      = bus.pix_sof ? '0 : x_q;
          cy      = bus.pix_sof ? '0 : y_q;
          acc_all = bus.pix_sof ? 4'b1111 : all1_q;
          acc_any = bus.pix_sof ? 4'b0000 : any1_q;
          rs      = resync_q
                  | (bus.pix_sof && ((x_q != '0) || (y_q != '0)))
                  | (!bus.pix_sof && (x_q == '0) && (y_q == '0));
          hit     = {(cx == '0)  && in_rng(cy),
                     (cy == '0)  && in_rng(cx),
                     (cx == MAX) && in_rng(cy),
                     (cy == MAX) && in_rng(cx)};
          all1_d   = acc_all & (~hit | {4{bus.pix_data}});
          any1_d   = acc_any | (hit & {4{bus.pix_data}});
          resync_d = rs;
          x_d      = cx + TILE_BITS'(1);
          y_d      = (cx == MAX) ? cy + TILE_BITS'(1) : cy;
          if ((cx == MAX) && (cy == MAX)) begin
            state_d       = DONE;
            walls_d       = all1_d;
            err_d         = (|(any1_d & ~all1_d)) | rs;
            walls_valid_d = 1'b1;
            pix_ready_d   = 1'b0;
          end
        end
      end
      DONE: begin
        pix_ready_d   = 1'b0;
        walls_valid_d = 1'b1;
        if (bus.walls_ready) begin
          state_d       = COLLECT;
          x_d           = '0;
          y_d           = '0;
          all1_d        = 4'b1111;
          any1_d        = 4'b0000;
          resync_d      = 1'b0;
          walls_valid_d = 1'b0;
          pix_ready_d   = 1'b1;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= COLLECT;
      x_q           <= '0;
      y_q           <= '0;
      all1_q        <= 4'b1111;
      any1_q        <= 4'b0000;
      resync_q      <= 1'b0;
      walls_q       <= 4'b0000;
      err_q         <= 1'b0;
      walls_valid_q <= 1'b0;
      pix_ready_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      all1_q        <= all1_d;
      any1_q        <= any1_d;
      resync_q      <= resync_d;
      walls_q       <= walls_d;
      err_q         <= err_d;
      walls_valid_q <= walls_valid_d;
      pix_ready_q   <= pix_ready_d;
    end
  end

  assign bus.pix_ready   = pix_ready_q;
  assign bus.walls_valid = walls_valid_q;
  assign bus.walls       = walls_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_wall_flag_decoder.sv
// Directed bench for wall_flag_decoder: streams hand-designed 16x16 tiles and checks
// the decoded wall flags, error bit and handshake timing.
module tb_wall_flag_decoder;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   w;

  wall_flag_if bus ();

  wall_flag_decoder #(.TILE_BITS(4), .EDGE_MARGIN(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tile kinds: 0 blank, 1 solid, 2 left+top, 3 partial right + two corners,
  // 4 four corners only, 5 bottom only, 6 bottom+left.
  function automatic logic pix_of(input int kind, input int x, input int y);
    case (kind)
      0: return 1'b0;
      1: return 1'b1;
      2: return (x == 0) || (y == 0);
      3: return ((x == 15) && (y != 7)) || ((x == 0) && (y == 0)) || ((x == 15) && (y == 15));
      4: return ((x == 0) || (x == 15)) && ((y == 0) || (y == 15));
      5: return (y == 15);
      6: return (y == 15) || (x == 0);
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Presents one beat and returns after the edge that accepts it; waited = stall cycles.
  task automatic send_beat(input logic d, input logic sof, output int waited);
    int guard;
    guard = 0;
    bus.pix_valid = 1'b1;
    bus.pix_data  = d;
    bus.pix_sof   = sof;
    while (!bus.pix_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 100) check("ready_timeout", 4'(guard >= 100), 4'd0);
    @(posedge clk); #1;
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
    waited = guard;
  endtask

  task automatic send_tile(input int kind, input int nbeats, output int first_wait);
    int wt;
    first_wait = 0;
    for (int i = 0; i < nbeats; i++) begin
      send_beat(pix_of(kind, i % 16, i / 16), i == 0, wt);
      if (i == 0) first_wait = wt;
    end
  endtask

  task automatic check_result(input string tag, input logic [3:0] ew, input logic ee);
    check({tag, "_valid"}, 4'(bus.walls_valid), 4'd1);
    check({tag, "_walls"}, bus.walls, ew);
    check({tag, "_err"},   4'(bus.err), 4'(ee));
    check({tag, "_rdy"},   4'(bus.pix_ready), 4'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.pix_valid   = 1'b0;
    bus.pix_data    = 1'b0;
    bus.pix_sof     = 1'b0;
    bus.walls_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 4'(bus.walls_valid), 4'd0);
    check("rst_rdy",   4'(bus.pix_ready), 4'd0);
    check("rst_walls", bus.walls, 4'b0000);
    check("rst_err",   4'(bus.err), 4'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_rdy", 4'(bus.pix_ready), 4'd1);

    // Left+top tile, result one cycle after the last beat
    send_tile(2, 256, w);
    check_result("lt", 4'b1100, 1'b0);

    // Hold off consumer: result stable, pixel beats ignored
    bus.pix_valid = 1'b1;
    bus.pix_sof   = 1'b1;
    bus.pix_data  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check_result("hold", 4'b1100, 1'b0);
    end
    bus.pix_valid   = 1'b0;
    bus.pix_sof     = 1'b0;
    bus.walls_ready = 1'b1;
    @(posedge clk); #1;
    check("rel_valid", 4'(bus.walls_valid), 4'd0);
    check("rel_rdy",   4'(bus.pix_ready), 4'd1);

    // Back-to-back blank then solid with consumer always ready
    send_tile(0, 256, w);
    check("blank_wait", 4'(w), 4'd0);
    check_result("blank", 4'b0000, 1'b0);
    send_tile(1, 256, w);
    check("solid_gap", 4'(w), 4'd1);
    check_result("solid", 4'b1111, 1'b0);

    // Partially drawn right edge, then corners-only
    send_tile(3, 256, w);
    check_result("partial", 4'b0000, 1'b1);
    send_tile(4, 256, w);
    check_result("corners", 4'b0000, 1'b0);

    // Resync: sof arrives on beat 100, restarting a clean bottom-only tile
    send_tile(0, 100, w);
    send_tile(5, 256, w);
    check_result("resync", 4'b0001, 1'b1);
    send_tile(5, 256, w);
    check_result("clean", 4'b0001, 1'b0);

    // Asynchronous reset mid-tile
    send_tile(1, 50, w);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_walls", bus.walls, 4'b0000);
    check("mid_rst_err",   4'(bus.err), 4'd0);
    check("mid_rst_rdy",   4'(bus.pix_ready), 4'd0);
    check("mid_rst_valid", 4'(bus.walls_valid), 4'd0);
    @(posedge clk); #3;
    rst = 1'b0;

    // Asynchronous reset while holding a result in DONE
    bus.walls_ready = 1'b0;
    send_tile(1, 256, w);
    check_result("pre_rst", 4'b1111, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("done_rst_valid", 4'(bus.walls_valid), 4'd0);
    check("done_rst_walls", bus.walls, 4'b0000);
    check("done_rst_err",   4'(bus.err), 4'd0);
    check("done_rst_rdy",   4'(bus.pix_ready), 4'd0);
    @(posedge clk); #3;
    rst = 1'b0;

    // Fresh bottom+left tile after reset
    send_tile(6, 256, w);
    check_result("bl", 4'b1001, 1'b0);
    bus.walls_ready = 1'b1;
    @(posedge clk); #1;
    check("final_rdy", 4'(bus.pix_ready), 4'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
